burst_scratchpad_slave: RTL

Bus-slave scratchpad memory that answers the burst read/write transactions issued by the DMA custom-instruction block's bus master. It sits downstream of that block on the shared wired-OR bus. It decodes a fixed address window, streams read bursts out one word per cycle, and absorbs write bursts. Used as the far-end memory for DMA transfers and as a standalone bench target for DMA verification.

---
 rtl/burst_scratchpad_slave_pkg.sv | 23 ++
 rtl/burst_scratchpad_slave_ram.sv | 30 +++
 rtl/burst_scratchpad_slave.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/burst_scratchpad_slave_pkg.sv
// Shared definitions for the burst scratchpad slave: FSM state encoding
// and bus field constants.
package burst_scratchpad_slave_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_FETCH = 3'd1,
        S_RD_DATA  = 3'd2,
        S_RD_END   = 3'd3,
        S_WR_DATA  = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    localparam int         BURST_W = 8;
    localparam logic [3:0] BE_FULL = 4'hF;

    // Width for ptr + burst_size such that the sum can never overflow,
    // even when the word address is narrower than the burst field.
    function automatic int sum_width(input int w);
        return (w + 1 > BURST_W + 1) ? (w + 1) : (BURST_W + 1);
    endfunction

endpackage

// File: rtl/burst_scratchpad_slave_ram.sv
// Single-port synchronous scratchpad RAM, 32-bit words, per-byte write
// enables, one cycle read latency. Contents survive reset.
module scratchpad_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clock,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane writes and read-first registered read of the same address.
    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we && i_be[l]) begin
                r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_scratchpad_slave.sv
// Burst bus slave in front of a scratchpad RAM. Decodes a fixed address
// window, streams read bursts one word per cycle and absorbs write bursts.
// Every output is zero outside an active response (wired-OR bus).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for begin_transaction_in with an address hit
// S_RD_FETCH | first RAM read issued for the captured pointer
// S_RD_DATA  | one read word per cycle, next read pre-issued
// S_RD_END   | end_transaction_out pulse after the last read word
// S_WR_DATA  | absorbing write words until end_transaction_in
// S_ERR      | range error reported; writes wait for end_transaction_in
module burst_scratchpad_slave
    import burst_scratchpad_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS  = 32'h5000_0000,
    parameter int          NR_OF_ENTRIES = 512
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               begin_transaction_in,
    input  logic [31:0]        address_data_in,
    input  logic               read_n_write_in,
    input  logic [BURST_W-1:0] burst_size_in,
    input  logic [3:0]         byte_enables_in,
    input  logic               data_valid_in,
    input  logic               end_transaction_in,
    output logic [31:0]        address_data_out,
    output logic               data_valid_out,
    output logic               end_transaction_out,
    output logic               error_out
);

    localparam int W     = $clog2(NR_OF_ENTRIES);
    localparam int SUM_W = sum_width(W);
    localparam logic [SUM_W-1:0] LAST_IDX = SUM_W'(NR_OF_ENTRIES - 1);

    state_t             r_state;
    logic [W-1:0]       r_ptr;
    logic [BURST_W-1:0] r_remaining;
    logic               r_rnw;
    logic [3:0]         r_be;
    logic               r_wr_done;
    logic               r_data_valid;
    logic               r_end_out;
    logic               r_error;

    logic               w_hit;
    logic [W-1:0]       w_ptr_in;
    logic [SUM_W-1:0]   w_sum;
    logic               w_range_err;
    logic               w_wr_fire;
    logic [31:0]        w_ram_rdata;
    logic               w_unused_addr_lsbs;

    // Address decode and up-front range check for the begin cycle.
    assign w_hit       = (address_data_in[31:W+2] == BASE_ADDRESS[31:W+2]);
    assign w_ptr_in    = address_data_in[W+1:2];
    assign w_sum       = {{(SUM_W-W){1'b0}}, w_ptr_in}
                       + {{(SUM_W-BURST_W){1'b0}}, burst_size_in};
    assign w_range_err = (w_sum > LAST_IDX);

    // The byte offset within a word carries no meaning for this slave.
    assign w_unused_addr_lsbs = ^address_data_in[1:0];

    // A write word lands even in the cycle that ends the transaction.
    assign w_wr_fire = (r_state == S_WR_DATA) && data_valid_in && !r_wr_done;

    scratchpad_ram #(
        .DEPTH (NR_OF_ENTRIES),
        .AW    (W)
    ) u_ram (
        .clock   (clock),
        .i_addr  (r_ptr),
        .i_we    (w_wr_fire),
        .i_be    (r_be),
        .i_wdata (address_data_in),
        .o_rdata (w_ram_rdata)
    );

    // Transaction FSM with registered bus outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_rnw        <= 1'b0;
            r_be         <= '0;
            r_wr_done    <= 1'b0;
            r_data_valid <= 1'b0;
            r_end_out    <= 1'b0;
            r_error      <= 1'b0;
        end else if (r_state != S_IDLE && end_transaction_in) begin
            r_state      <= S_IDLE;
            r_data_valid <= 1'b0;
            r_end_out    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (begin_transaction_in && w_hit) begin
                        r_ptr       <= w_ptr_in;
                        r_remaining <= burst_size_in;
                        r_rnw       <= read_n_write_in;
                        r_be        <= (burst_size_in != '0) ? BE_FULL : byte_enables_in;
                        r_wr_done   <= 1'b0;
                        if (w_range_err) begin
                            r_state   <= S_ERR;
                            r_error   <= 1'b1;
                            r_end_out <= read_n_write_in;
                        end else if (read_n_write_in) begin
                            r_state <= S_RD_FETCH;
                        end else begin
                            r_state <= S_WR_DATA;
                        end
                    end
                end
                S_RD_FETCH: begin
                    r_ptr        <= r_ptr + 1'b1;
                    r_data_valid <= 1'b1;
                    r_state      <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (r_remaining == '0) begin
                        r_data_valid <= 1'b0;
                        r_end_out    <= 1'b1;
                        r_state      <= S_RD_END;
                    end else begin
                        r_remaining <= r_remaining - 1'b1;
                        r_ptr       <= r_ptr + 1'b1;
                    end
                end
                S_RD_END: begin
                    r_end_out <= 1'b0;
                    r_state   <= S_IDLE;
                end
                S_WR_DATA: begin
                    if (w_wr_fire) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_remaining == '0) begin
                            r_wr_done <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    r_error   <= 1'b0;
                    r_end_out <= 1'b0;
                    if (r_rnw) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM output is itself a register; it is masked by the registered valid
    // so the shared bus sees zero whenever this slave is not driving.
    assign address_data_out    = r_data_valid ? w_ram_rdata : 32'h0;
    assign data_valid_out      = r_data_valid;
    assign end_transaction_out = r_end_out;
    assign error_out           = r_error;

endmodule
